// File: rtl/pong_pkg.sv
// Shared definitions for the pong match logic: FSM state encodings, key byte
// codes and winner encodings. Other pong blocks import the key constants too.
package pong_pkg;

  // Match FSM states; the numeric values are visible on o_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Winner encodings driven on o_winner.
  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // Key byte codes: 'g' starts/serves, 'b' restarts the match.
  localparam logic [7:0] KEY_START   = 8'd103;
  localparam logic [7:0] KEY_RESTART = 8'd98;

  // Width of each score output.
  localparam int SCORE_W = 4;

endpackage

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector for a scored level from the ball block.
// The level is registered once, then compared with its previous sample, so a
// level held high yields exactly one single-cycle o_rise.
module pong_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic level_q, level_d;
  logic prev_q, prev_d;

  // Next-state: sample the input and keep one cycle of history.
  always_comb begin
    level_d = i_level;
    prev_d  = level_q;
  end

  // Input register and history register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  // Rise = registered sample high while the one before it was low.
  assign o_rise = level_q & ~prev_q;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong match controller: detects point events from the ball block, keeps both
// scores, sequences IDLE/SERVE/PLAY/POINT/OVER and drives the ball re-serve,
// freeze and serve-direction controls. All outputs come straight from flops.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter logic [7:0] START       = KEY_START,
  parameter logic [7:0] RESTART     = KEY_RESTART,
  parameter int         WIN_SCORE   = 7,
  parameter int         POINT_DELAY = 25_000_000,
  parameter int         AUTO_SERVE  = 1
) (
  input  logic               i_CLK,
  input  logic               i_RST_n,
  input  logic [7:0]         i_key_byte,
  input  logic               i_p1_scored,
  input  logic               i_p2_scored,
  output logic               o_ball_reset,
  output logic               o_ball_enable,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic [1:0]         o_winner,
  output logic [2:0]         o_state
);

  localparam int                 CNT_W     = (POINT_DELAY > 1) ? $clog2(POINT_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(POINT_DELAY - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(WIN_SCORE);

  // Saturating score increment: a score never passes the winning value.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  state_e             state_q, state_d;
  winner_e            winner_q, winner_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ball_reset_q, ball_reset_d;
  logic               ball_enable_q, ball_enable_d;
  logic               serve_dir_q, serve_dir_d;

  logic p1_rise, p2_rise;
  logic key_start, key_restart;

  pong_edge_detect u_p1_edge (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST_n),
    .i_level (i_p1_scored),
    .o_rise  (p1_rise)
  );

  pong_edge_detect u_p2_edge (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST_n),
    .i_level (i_p2_scored),
    .o_rise  (p2_rise)
  );

  assign key_start   = (i_key_byte == START);
  assign key_restart = (i_key_byte == RESTART);

  // Next-state and next-output logic for the match FSM, scores and delay counter.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    cnt_d       = cnt_q;
    serve_dir_d = serve_dir_q;

    if (key_restart) begin
      // Restart wins over start and over any point seen this cycle.
      state_d     = ST_IDLE;
      winner_d    = WIN_NONE;
      p1_score_d  = '0;
      p2_score_d  = '0;
      cnt_d       = '0;
      serve_dir_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_start) state_d = ST_SERVE;
        end
        ST_SERVE: begin
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          // P1 takes a tie; a simultaneous P2 edge is dropped.
          if (p1_rise) begin
            p1_score_d  = sat_inc(p1_score_q);
            serve_dir_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_POINT;
          end else if (p2_rise) begin
            p2_score_d  = sat_inc(p2_score_q);
            serve_dir_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_POINT;
          end
        end
        ST_POINT: begin
          if (cnt_q == CNT_LAST) begin
            // Counter parks at its last value while waiting for a manual serve.
            if (p1_score_q == SCORE_MAX) begin
              winner_d = WIN_P1;
              cnt_d    = '0;
              state_d  = ST_OVER;
            end else if (p2_score_q == SCORE_MAX) begin
              winner_d = WIN_P2;
              cnt_d    = '0;
              state_d  = ST_OVER;
            end else if ((AUTO_SERVE != 0) || key_start) begin
              cnt_d   = '0;
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // SERVE lasts one cycle, so entering it gives exactly one re-serve pulse.
    ball_reset_d  = key_restart || (state_d == ST_SERVE);
    ball_enable_d = (state_d == ST_PLAY);
  end

  // State, score and output registers.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q       <= ST_IDLE;
      winner_q      <= WIN_NONE;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      cnt_q         <= '0;
      ball_reset_q  <= 1'b0;
      ball_enable_q <= 1'b0;
      serve_dir_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      cnt_q         <= cnt_d;
      ball_reset_q  <= ball_reset_d;
      ball_enable_q <= ball_enable_d;
      serve_dir_q   <= serve_dir_d;
    end
  end

  assign o_ball_reset  = ball_reset_q;
  assign o_ball_enable = ball_enable_q;
  assign o_serve_dir   = serve_dir_q;
  assign o_p1_score    = p1_score_q;
  assign o_p2_score    = p2_score_q;
  assign o_winner      = winner_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: two instances (auto serve and manual serve)
// share one stimulus stream; a rule-level match model predicts each cycle's
// outputs into per-instance queues that a monitor drains and compares.
module tb_pong_score_keeper;

  localparam int W = 3;
  localparam int D = 10;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] win;
    logic       pulse;
    logic       en;
    logic       dir;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_byte;
  logic       p1_in, p2_in;

  logic       a_reset, a_en, a_dir, m_reset, m_en, m_dir;
  logic [3:0] a_p1, a_p2, m_p1, m_p2;
  logic [1:0] a_win, m_win;
  logic [2:0] a_st, m_st;

  pong_score_keeper #(.WIN_SCORE(W), .POINT_DELAY(D), .AUTO_SERVE(1)) u_auto (
    .i_CLK(clk), .i_RST_n(rst_n), .i_key_byte(key_byte),
    .i_p1_scored(p1_in), .i_p2_scored(p2_in),
    .o_ball_reset(a_reset), .o_ball_enable(a_en), .o_serve_dir(a_dir),
    .o_p1_score(a_p1), .o_p2_score(a_p2), .o_winner(a_win), .o_state(a_st)
  );

  pong_score_keeper #(.WIN_SCORE(W), .POINT_DELAY(D), .AUTO_SERVE(0)) u_manual (
    .i_CLK(clk), .i_RST_n(rst_n), .i_key_byte(key_byte),
    .i_p1_scored(p1_in), .i_p2_scored(p2_in),
    .o_ball_reset(m_reset), .o_ball_enable(m_en), .o_serve_dir(m_dir),
    .o_p1_score(m_p1), .o_p2_score(m_p2), .o_winner(m_win), .o_state(m_st)
  );

  exp_t act_a, act_m;
  assign act_a = {a_st, a_p1, a_p2, a_win, a_reset, a_en, a_dir};
  assign act_m = {m_st, m_p1, m_p2, m_win, m_reset, m_en, m_dir};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_m[$];

  // Reference model: game phase (0 idle,1 serve,2 play,3 point,4 over),
  // scores, winner, serve direction and cycles spent frozen after a point.
  int ph[2], sc1[2], sc2[2], who[2], waited[2];
  bit dir_m[2];
  // Scored-input samples seen at the last two clock edges.
  bit a_now, a_before, b_now, b_before;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    check({tag, ".state"}, a.st, e.st);
    check({tag, ".p1_score"}, a.p1, e.p1);
    check({tag, ".p2_score"}, a.p2, e.p2);
    check({tag, ".winner"}, a.win, e.win);
    check({tag, ".ball_reset"}, a.pulse, e.pulse);
    check({tag, ".ball_enable"}, a.en, e.en);
    check({tag, ".serve_dir"}, a.dir, e.dir);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; sc1[k] = 0; sc2[k] = 0; who[k] = 0; waited[k] = 0; dir_m[k] = 1'b0;
    end
    a_now = 0; a_before = 0; b_now = 0; b_before = 0;
  endtask

  task automatic model_step(input int k, input logic [7:0] key, input bit r1, input bit r2,
                            output exp_t e);
    bit pulse;
    bit auto_serve;
    pulse = 1'b0;
    auto_serve = (k == 0);
    if (key == 8'd98) begin
      ph[k] = 0; sc1[k] = 0; sc2[k] = 0; who[k] = 0; waited[k] = 0; dir_m[k] = 1'b0;
      pulse = 1'b1;
    end else begin
      case (ph[k])
        0: if (key == 8'd103) begin ph[k] = 1; pulse = 1'b1; end
        1: ph[k] = 2;
        2: begin
          if (r1) begin
            sc1[k] = (sc1[k] < W) ? sc1[k] + 1 : W; dir_m[k] = 1'b1; ph[k] = 3; waited[k] = 0;
          end else if (r2) begin
            sc2[k] = (sc2[k] < W) ? sc2[k] + 1 : W; dir_m[k] = 1'b0; ph[k] = 3; waited[k] = 0;
          end
        end
        3: begin
          waited[k]++;
          if (waited[k] >= D) begin
            if (sc1[k] == W) begin ph[k] = 4; who[k] = 1; end
            else if (sc2[k] == W) begin ph[k] = 4; who[k] = 2; end
            else if (auto_serve || key == 8'd103) begin ph[k] = 1; pulse = 1'b1; end
          end
        end
        default: ;
      endcase
    end
    e.st    = 3'(ph[k]);
    e.p1    = 4'(sc1[k]);
    e.p2    = 4'(sc2[k]);
    e.win   = 2'(who[k]);
    e.pulse = pulse;
    e.en    = (ph[k] == 2);
    e.dir   = dir_m[k];
  endtask

  // Apply one cycle of stimulus and queue the predicted response of each instance.
  task automatic drive(input logic [7:0] key, input bit a, input bit b);
    exp_t e;
    bit r1, r2;
    @(negedge clk);
    key_byte = key; p1_in = a; p2_in = b;
    r1 = a_now && !a_before;
    r2 = b_now && !b_before;
    model_step(0, key, r1, r2, e); q_a.push_back(e);
    model_step(1, key, r1, r2, e); q_m.push_back(e);
    a_before = a_now; a_now = a;
    b_before = b_now; b_now = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'd0, p1_in, p2_in);
  endtask

  // Monitor: after every clock edge, pop the prediction for that edge and compare.
  exp_t mon_a, mon_m;
  always begin
    @(posedge clk);
    #1;
    if (q_a.size() > 0) begin mon_a = q_a.pop_front(); compare("auto", act_a, mon_a); end
    if (q_m.size() > 0) begin mon_m = q_m.pop_front(); compare("manual", act_m, mon_m); end
  end

  exp_t zero_e;
  int   rnd;
  logic [7:0] rkey;
  bit   ra, rb;

  initial begin
    zero_e = '0;
    rst_n = 1'b0; key_byte = 8'd0; p1_in = 1'b0; p2_in = 1'b0;
    model_reset();
    #22;
    compare("auto.reset", act_a, zero_e);
    compare("manual.reset", act_m, zero_e);
    #10 rst_n = 1'b1;

    // Start a match, then a long P2 level (one point), manual serve for the second instance.
    drive(8'd103, 0, 0); idle(5);
    for (int i = 0; i < 50; i++) drive(8'd0, 0, 1);
    drive(8'd0, 0, 0); idle(5);
    drive(8'd103, 0, 0); idle(5);

    // Simultaneous rising edges: P1 takes the point.
    for (int i = 0; i < 3; i++) drive(8'd0, 1, 1);
    drive(8'd0, 0, 0); idle(20);
    drive(8'd103, 0, 0); idle(5);

    // P1 points until the match is over.
    for (int p = 0; p < 3; p++) begin
      drive(8'd0, 1, 0); drive(8'd0, 1, 0);
      drive(8'd0, 0, 0); idle(15);
      drive(8'd103, 0, 0); idle(4);
    end
    // START and scored edges while OVER.
    drive(8'd103, 0, 0); drive(8'd0, 0, 1); drive(8'd0, 0, 0); drive(8'd0, 1, 0);
    drive(8'd0, 0, 0); idle(3);

    // Restart mid-POINT, then confirm a full-length freeze on the next point.
    drive(8'd98, 0, 0); drive(8'd103, 0, 0); idle(3);
    drive(8'd0, 0, 1); drive(8'd0, 0, 1); drive(8'd0, 0, 0); idle(5);
    drive(8'd98, 0, 0); idle(3);
    drive(8'd103, 0, 0); idle(3);
    drive(8'd0, 1, 0); drive(8'd0, 0, 0); idle(16);

    // Randomized play.
    ra = 0; rb = 0;
    for (int i = 0; i < 4000; i++) begin
      rnd = $urandom_range(0, 199);
      if (rnd == 0) rkey = 8'd98;
      else if (rnd < 20) rkey = 8'd103;
      else if (rnd < 26) rkey = 8'($urandom_range(0, 255));
      else rkey = 8'd0;
      if ($urandom_range(0, 7) == 0) ra = ~ra;
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      drive(rkey, ra, rb);
    end

    // Asynchronous reset in the middle of PLAY.
    drive(8'd98, 0, 0); drive(8'd103, 0, 0); idle(4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    compare("auto.async_reset", act_a, zero_e);
    compare("manual.async_reset", act_m, zero_e);
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    drive(8'd103, 0, 0); idle(4);
    drive(8'd0, 0, 1); drive(8'd0, 0, 0); idle(14);

    @(posedge clk);
    #2;
    check("auto.queue_drained", q_a.size(), 0);
    check("manual.queue_drained", q_m.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
